// File: rtl/multicycle_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle control unit: state codes,
//          opcode constants, datapath mux/ALU-op encodings, the control
//          output payload, and the ALU control decoder that consumes alu_op.
// Ports:   none (package).
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned WAIT_CNT_W = 8;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned ALUCTL_W   = 3;

  // Opcodes recognised by the decode state
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  // FSM state encoding
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_FETCH     = 4'd0;
  localparam state_t ST_DECODE    = 4'd1;
  localparam state_t ST_MEM_ADDR  = 4'd2;
  localparam state_t ST_MEM_READ  = 4'd3;
  localparam state_t ST_MEM_WB    = 4'd4;
  localparam state_t ST_MEM_WRITE = 4'd5;
  localparam state_t ST_EXEC_R    = 4'd6;
  localparam state_t ST_EXEC_I    = 4'd7;
  localparam state_t ST_ALU_WB    = 4'd8;
  localparam state_t ST_BRANCH    = 4'd9;

  // ALU operand A select
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_AREG  = 2'b10;

  // ALU operand B select
  localparam logic [SEL_W-1:0] SRCB_BREG  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  // ALU operation class handed to the ALU control decoder
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  // Result bus select
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  // ALU control codes produced by the decoder
  localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 3'b101;

  // Control outputs for one cycle
  typedef struct packed {
    logic             mem_req;
    logic             mem_write;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] result_src;
    logic             illegal_instr;
    logic             bus_err;
  } ctrl_t;

  // ALU control decoder; shares the alu_op constants with the FSM
  function automatic logic [ALUCTL_W-1:0] alu_decode(
    input logic [SEL_W-1:0] alu_op,
    input logic [2:0]       funct3,
    input logic             op5,
    input logic             funct7b5
  );
    logic [ALUCTL_W-1:0] ctl;
    ctl = ALUCTL_ADD;
    case (alu_op)
      ALUOP_ADD: ctl = ALUCTL_ADD;
      ALUOP_SUB: ctl = ALUCTL_SUB;
      default: begin
        case (funct3)
          3'b000:  ctl = (op5 && funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  ctl = ALUCTL_SLT;
          3'b110:  ctl = ALUCTL_OR;
          3'b111:  ctl = ALUCTL_AND;
          default: ctl = ALUCTL_ADD;
        endcase
      end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Purpose: bundle of datapath/memory status inputs and control outputs of
//          the multicycle control unit.
// Modports: slave  - the control unit (reads opcode/zero/mem_ready, drives controls)
//           master - the datapath/memory side (drives status, reads controls)
interface multicycle_control_unit_if;
  import multicycle_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                mem_req;
  logic                mem_write;
  logic                adr_src;
  logic                ir_write;
  logic                pc_write;
  logic                reg_write;
  logic [SEL_W-1:0]    alu_src_a;
  logic [SEL_W-1:0]    alu_src_b;
  logic [SEL_W-1:0]    alu_op;
  logic [SEL_W-1:0]    result_src;
  logic                illegal_instr;
  logic                bus_err;

  modport slave (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, bus_err
  );

  modport master (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, bus_err
  );

endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Purpose: counts consecutive not-ready cycles of a memory wait and flags
//          the cycle on which the wait must be abandoned.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          waiting       - FSM is in a memory wait state this cycle
//          mem_ready     - memory completed the request this cycle
//          clear         - restart the count at the next edge
//          expired       - combinational: this cycle is the timeout cycle
module mem_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic mem_ready,
  input  logic clear,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;
  logic                  stall;

  assign stall   = waiting && !mem_ready;
  // The count holds the number of not-ready cycles already seen, so the
  // TIMEOUT_CYCLES-th consecutive not-ready cycle sees TIMEOUT_CYCLES-1.
  assign expired = stall && (cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: Moore control FSM of a multicycle RISC-V style datapath with
//          bounded memory waits.
// Ports:   clk  - single clock, rising edge
//          rst  - synchronous active-high reset; forces all controls low
//          bus  - slave modport: opcode/zero/mem_ready in, datapath
//                 controls and error pulses out (same-cycle Moore decode)
module multicycle_control_unit
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_unit_if.slave  bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   waiting;
  logic   expired;
  logic   timer_clear;

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                   (state_q == ST_MEM_WRITE);

  // A timeout in FETCH stays in FETCH, so it must restart the count explicitly
  assign timer_clear = (state_d != state_q) || expired;

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .waiting   (waiting),
    .mem_ready (bus.mem_ready),
    .clear     (timer_clear),
    .expired   (expired)
  );

  // Next state and control decode
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        if (expired) begin
          ctrl.bus_err = 1'b1;
          state_d      = ST_FETCH;
        end else if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
          OP_RTYPE:          state_d = ST_EXEC_R;
          OP_ITYPE:          state_d = ST_EXEC_I;
          OP_BRANCH:         state_d = ST_BRANCH;
          default: begin
            ctrl.illegal_instr = 1'b1;
            state_d            = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_AREG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (bus.opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        if (expired) begin
          ctrl.bus_err = 1'b1;
          state_d      = ST_FETCH;
        end else if (bus.mem_ready) begin
          state_d = ST_MEM_WB;
        end
      end
      ST_MEM_WB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        if (expired) begin
          ctrl.bus_err = 1'b1;
          state_d      = ST_FETCH;
        end else if (bus.mem_ready) begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = SRCA_AREG;
        ctrl.alu_src_b = SRCB_BREG;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = SRCA_AREG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a  = SRCA_AREG;
        ctrl.alu_src_b  = SRCB_BREG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = bus.zero;
        state_d         = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    // Reset silences every control in the same cycle, whatever the state
    if (rst) begin
      ctrl    = '0;
      state_d = ST_FETCH;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.mem_req       = ctrl.mem_req;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.adr_src       = ctrl.adr_src;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.result_src    = ctrl.result_src;
  assign bus.illegal_instr = ctrl.illegal_instr;
  assign bus.bus_err       = ctrl.bus_err;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Purpose: scoreboard bench for multicycle_control_unit. An instruction-level
//          model expands each randomized instruction into its per-cycle
//          control pattern; a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam int T = 16;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       illegal_instr;
    logic       bus_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   cyc_no = 0;

  // Driver-side bookkeeping
  int   cyc_idx   = 0;
  int   rst_at    = -1;
  bit   rst_hit   = 1'b0;
  bit   quiet_rdy = 1'b0;
  int   z_mode    = -1;

  function automatic exp_t mk(logic req, logic wr, logic adr, logic irw,
                              logic pcw, logic rgw, logic [1:0] a,
                              logic [1:0] b, logic [1:0] op, logic [1:0] rs,
                              logic ill, logic be);
    exp_t e;
    e.mem_req = req; e.mem_write = wr; e.adr_src = adr; e.ir_write = irw;
    e.pc_write = pcw; e.reg_write = rgw; e.alu_src_a = a; e.alu_src_b = b;
    e.alu_op = op; e.result_src = rs; e.illegal_instr = ill; e.bus_err = be;
    return e;
  endfunction

  // Per-phase control patterns taken from the state table
  function automatic exp_t v_fetch(logic done, logic be);
    return mk(1, 0, 0, done, done, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, be);
  endfunction
  function automatic exp_t v_decode(logic ill);
    return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, ill, 0);
  endfunction
  function automatic exp_t v_mem_addr();
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic exp_t v_mem_rd(logic be);
    return mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, be);
  endfunction
  function automatic exp_t v_mem_wb();
    return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
  endfunction
  function automatic exp_t v_mem_wr(logic be);
    return mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, be);
  endfunction
  function automatic exp_t v_exec_r();
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
  endfunction
  function automatic exp_t v_exec_i();
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic exp_t v_alu_wb();
    return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic exp_t v_branch(logic z);
    return mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0);
  endfunction

  function automatic logic rand_rdy();
    return quiet_rdy ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction
  function automatic logic rand_z();
    return (z_mode < 0) ? 1'($urandom_range(0, 1)) : (z_mode != 0);
  endfunction

  // One clock of stimulus plus its expected controls
  task automatic cyc(input logic rdy, input logic [6:0] op, input logic z,
                     input exp_t e);
    @(posedge clk);
    #1;
    if (cyc_idx == rst_at) begin
      rst = 1'b1;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode    = 7'($urandom);
      bus.zero      = 1'($urandom_range(0, 1));
      exp_q.push_back('0);
      rst_hit = 1'b1;
    end else begin
      rst = 1'b0;
      bus.mem_ready = rdy;
      bus.opcode    = op;
      bus.zero      = z;
      exp_q.push_back(e);
    end
    cyc_idx++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode    = 7'($urandom);
      bus.zero      = 1'($urandom_range(0, 1));
      exp_q.push_back('0);
    end
  endtask

  // Memory wait: nwait not-ready cycles then ready, abandoned on the T-th miss
  task automatic wait_phase(input int kind, input int nwait,
                            input logic [6:0] op, output bit ok);
    logic rdy;
    logic be;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < T; i++) begin
      rdy = (i >= nwait);
      be  = !rdy && (i == T - 1);
      case (kind)
        0:       e = v_fetch(rdy, be);
        1:       e = v_mem_rd(be);
        default: e = v_mem_wr(be);
      endcase
      cyc(rdy, (kind == 0) ? 7'($urandom) : op, rand_z(), e);
      if (rst_hit || be) return;
      if (rdy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011;
  endfunction

  // Expand one instruction into its cycle-by-cycle expectation
  task automatic do_instr(input logic [6:0] op, input int fw, input int mw,
                          input int ra);
    bit   ok;
    logic z;
    cyc_idx = 0;
    rst_at  = ra;
    rst_hit = 1'b0;
    wait_phase(0, fw, op, ok);
    if (rst_hit || !ok) return;
    cyc(rand_rdy(), op, rand_z(), v_decode(!legal(op)));
    if (rst_hit || !legal(op)) return;
    case (op)
      7'b0110011: begin
        cyc(rand_rdy(), op, rand_z(), v_exec_r());
        if (rst_hit) return;
        cyc(rand_rdy(), op, rand_z(), v_alu_wb());
      end
      7'b0010011: begin
        cyc(rand_rdy(), op, rand_z(), v_exec_i());
        if (rst_hit) return;
        cyc(rand_rdy(), op, rand_z(), v_alu_wb());
      end
      7'b0000011: begin
        cyc(rand_rdy(), op, rand_z(), v_mem_addr());
        if (rst_hit) return;
        wait_phase(1, mw, op, ok);
        if (rst_hit || !ok) return;
        cyc(rand_rdy(), op, rand_z(), v_mem_wb());
      end
      7'b0100011: begin
        cyc(rand_rdy(), op, rand_z(), v_mem_addr());
        if (rst_hit) return;
        wait_phase(2, mw, op, ok);
      end
      default: begin
        z = rand_z();
        cyc(rand_rdy(), op, z, v_branch(z));
      end
    endcase
    if (rst_hit) return;
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12) return 0;
    if (r < 17) return int'($urandom_range(1, 3));
    if (r == 17) return T - 1;
    if (r == 18) return T;
    return T + 3;
  endfunction

  function automatic logic [6:0] rand_op();
    logic [6:0] op;
    case ($urandom_range(0, 6))
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      4: op = 7'b1100011;
      default: begin
        op = 7'($urandom);
        if (legal(op)) op = 7'b1111111;
      end
    endcase
    return op;
  endfunction

  // Monitor: one expected control pattern per cycle
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.mem_req = bus.mem_req; g.mem_write = bus.mem_write;
      g.adr_src = bus.adr_src; g.ir_write = bus.ir_write;
      g.pc_write = bus.pc_write; g.reg_write = bus.reg_write;
      g.alu_src_a = bus.alu_src_a; g.alu_src_b = bus.alu_src_b;
      g.alu_op = bus.alu_op; g.result_src = bus.result_src;
      g.illegal_instr = bus.illegal_instr; g.bus_err = bus.bus_err;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL ctrl cycle %0d: got %b want %b (req,wr,adr,irw,pcw,rgw,a,b,op,rs,ill,berr)",
                 cyc_no, g, e);
      end
      cyc_no++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset(2);

    // Directed scenarios
    quiet_rdy = 1'b1;
    do_instr(7'b0110011, 0, 0, -1);           // R-type, 4 cycles
    quiet_rdy = 1'b0;
    do_instr(7'b0000011, 0, 3, -1);           // load with 3 read waits
    z_mode = 1;
    do_instr(7'b1100011, 0, 0, -1);           // branch taken
    z_mode = 0;
    do_instr(7'b1100011, 0, 0, -1);           // branch not taken
    z_mode = -1;
    do_instr(7'b0110011, T, 0, -1);           // fetch timeout
    do_instr(7'b0010011, T - 1, 0, -1);       // longest wait that still completes
    do_instr(7'b1111111, 0, 0, -1);           // illegal opcode
    do_instr(7'b0100011, 0, 3, 4);            // reset in 2nd store wait
    do_instr(7'b0100011, 0, T, -1);           // store timeout
    do_instr(7'b0000011, 0, T, -1);           // load timeout
    do_instr(7'b0110011, 10, 0, 5);           // reset mid fetch wait
    do_instr(7'b0110011, T - 1, 0, -1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      int ra;
      ra = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_instr(rand_op(), rand_wait(), rand_wait(), ra);
      if (rst_hit) do_reset(int'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, consecutive not-ready cycles before a memory wait aborts (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory accepted or completed the current request this cycle.
REQ-007 mem_req  output  1  memory request, held until mem_ready.
REQ-008 mem_write  output  1  request is a write.
REQ-009 adr_src  output  1  memory address select: 0 = PC, 1 = result bus.
REQ-010 ir_write, pc_write, reg_write  output  1 each  register write strobes.
REQ-011 alu_src_a  output  2  00 PC, 01 OldPC, 10 A reg.
REQ-012 alu_src_b  output  2  00 B reg, 01 immediate, 10 constant 4.
REQ-013 alu_op  output  2  00 add, 01 sub, 10 funct decode; feeds the existing ALU control decoder.
REQ-014 result_src  output  2  00 ALUOut, 01 memory data, 10 ALU result.
REQ-015 illegal_instr, bus_err  output  1 each  single-cycle error pulses.

Function
REQ-016 Moore FSM, states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH; outputs not listed for a state SHALL be 0.
REQ-017 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1, which also moves to DECODE.
REQ-018 DECODE (1 cycle): alu_src_a=01, alu_src_b=01, alu_op=00; next state by opcode: 0000011/0100011 -> MEM_ADDR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, otherwise illegal_instr=1 and -> FETCH.
REQ-019 MEM_ADDR: alu_src_a=10, alu_src_b=01, alu_op=00; -> MEM_READ for 0000011, else MEM_WRITE.
REQ-020 MEM_READ: mem_req=1, adr_src=1, result_src=00; -> MEM_WB on mem_ready. MEM_WB: result_src=01, reg_write=1; -> FETCH.
REQ-021 MEM_WRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00; -> FETCH on mem_ready.
REQ-022 EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=00; both -> ALU_WB. ALU_WB: result_src=00, reg_write=1; -> FETCH.
REQ-023 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; -> FETCH.
REQ-024 Cycle counts at zero wait: R/I 4, load 5, store 4, branch 3; each not-ready cycle in FETCH, MEM_READ or MEM_WRITE adds one.
REQ-025 Wait counter (8 bit) SHALL increment on every wait-state cycle with mem_ready=0 and clear on any state change.
REQ-026 When the counter equals TIMEOUT_CYCLES-1 and mem_ready=0, bus_err SHALL be 1 that cycle, no write strobe fires, and next state SHALL be FETCH.
REQ-027 mem_ready outside wait states SHALL be ignored; mem_ready=1 on the first wait cycle SHALL complete with zero added latency.

Reset
REQ-028 rst=1 SHALL force next state FETCH and clear the wait counter from any state, including mid-wait.
REQ-029 In every cycle with rst=1, all outputs SHALL be 0 regardless of state.
REQ-030 The first cycle after rst deasserts SHALL be FETCH with mem_req=1.

Structure
REQ-031 Package multicycle_ctrl_pkg SHALL hold the state enum, opcode constants, and alu_src_a/alu_src_b/alu_op/result_src encodings; the ALU control decoder SHALL use the same alu_op constants.
REQ-032 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer (inputs: waiting, mem_ready, clear; output: expired).

Verification
REQ-033 opcode=0110011, mem_ready=1 always -> FETCH, DECODE, EXEC_R, ALU_WB; alu_op=10 in cycle 3, reg_write=1 only in cycle 4.
REQ-034 opcode=0000011, mem_ready low for 3 MEM_READ cycles -> mem_req high 4 cycles in MEM_READ, reg_write with result_src=01 one cycle later, 8 cycles total.
REQ-035 opcode=1100011 with zero=1 -> pc_write=1 in BRANCH; repeat with zero=0 -> pc_write=0; 3 cycles each.
REQ-036 TIMEOUT_CYCLES=16, mem_ready=0 in FETCH -> bus_err=1 on the 16th FETCH cycle, ir_write never 1, FETCH re-entered with counter 0.
REQ-037 opcode=1111111 -> illegal_instr=1 for one DECODE cycle, then FETCH, with no reg_write or mem_write.
REQ-038 rst=1 during the second MEM_WRITE wait cycle -> mem_req and mem_write 0 that cycle, FETCH after deassertion, no bus_err.
